// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int XLEN          = 32;
    localparam int DEF_LINES     = 32;
    localparam int DEF_LINE_BITS = 256;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int word_width(input int line_bits);
        return $clog2(line_bits / XLEN);
    endfunction

    // Tag is what remains of the byte address above index and byte offset.
    function automatic int tag_width(input int lines, input int line_bits);
        return XLEN - $clog2(lines) - $clog2(line_bits / 8);
    endfunction

    localparam int IDX_W  = idx_width(DEF_LINES);
    localparam int WORD_W = word_width(DEF_LINE_BITS);
    localparam int TAG_W  = tag_width(DEF_LINES, DEF_LINE_BITS);

endpackage

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data storage for the data cache: one combinational read
// port and one synchronous whole-line write port.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES     = DEF_LINES,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int IDX_BITS  = idx_width(LINES),
    parameter int TAG_BITS  = tag_width(LINES, LINE_BITS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic                 wr_dirty
);

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // NOTE: tag/data arrays have no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Hits complete with no stall; misses freeze the pipeline while the FSM evicts and refills.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int LINES     = DEF_LINES,
    parameter int LINE_BITS = DEF_LINE_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    localparam int IW = idx_width(LINES);
    localparam int WW = word_width(LINE_BITS);
    localparam int OW = WW + 2;
    localparam int TW = tag_width(LINES, LINE_BITS);

    state_t state, state_next;

    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [WW-1:0] req_word;
    logic          addr_unused;

    logic [TW-1:0] miss_tag;
    logic [IW-1:0] miss_idx;

    logic [IW-1:0]        rd_idx;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TW-1:0]        rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic [31:0]          rd_word;

    logic                 wr_en;
    logic [IW-1:0]        wr_idx;
    logic [TW-1:0]        wr_tag;
    logic [LINE_BITS-1:0] wr_line;
    logic                 wr_dirty;

    logic hit;
    logic miss;

    assign req_word    = addr_i[2 +: WW];
    assign req_idx     = addr_i[OW +: IW];
    assign req_tag     = addr_i[XLEN-1 -: TW];
    assign addr_unused = ^addr_i[1:0];

    // Outside IDLE the arrays are addressed by the captured miss, so mem_* never depend on the live request.
    assign rd_idx = (state == IDLE) ? req_idx : miss_idx;

    dcache_sram #(
        .LINES     (LINES),
        .LINE_BITS (LINE_BITS),
        .IDX_BITS  (IW),
        .TAG_BITS  (TW)
    ) u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_line  (wr_line),
        .wr_dirty (wr_dirty)
    );

    assign hit     = (state == IDLE) & req_i & rd_valid & (rd_tag == req_tag);
    assign miss    = (state == IDLE) & req_i & ~hit;
    assign rd_word = rd_line[{req_word, 5'b0} +: 32];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            miss_tag <= '0;
            miss_idx <= '0;
        end else if (miss) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
        end
    end

    // A store hit rewrites the whole line with one word replaced; a refill writes the fetched line clean.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        wr_en    = 1'b0;
        wr_idx   = rd_idx;
        wr_tag   = rd_tag;
        wr_line  = rd_line;
        wr_dirty = 1'b0;
        if (hit && we_i) begin
            wr_en                          = 1'b1;
            wr_line[{req_word, 5'b0} +: 32] = wdata_i;
            wr_dirty                       = 1'b1;
        end else if (state == ALLOCATE && mem_ack_i) begin
            wr_en    = 1'b1;
            wr_idx   = miss_idx;
            wr_tag   = miss_tag;
            wr_line  = mem_rdata_i;
            wr_dirty = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    state_next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state)
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {rd_tag, miss_idx, {OW{1'b0}}};
                mem_wdata_o = rd_line;
            end
            ALLOCATE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {miss_tag, miss_idx, {OW{1'b0}}};
            end
            default: ;
        endcase
    end

    // Reset forces the freeze low at once, even while a request is held in IDLE.
    assign stall_o = rst_i & ((state != IDLE) | miss);
    assign rdata_o = (hit && !we_i) ? rd_word : 32'h0;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: refill, hits, write-back eviction,
// write-allocate store miss and asynchronous reset during a refill.
module tb_dcache_controller;

    logic         clk_i;
    logic         rst_i;
    logic         req_i;
    logic         we_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    int checks;
    int errors;

    logic [255:0] mem_model [logic [31:0]];

    int           r_stalls;
    int           r_rd_cnt;
    int           r_wb_cnt;
    logic [31:0]  r_rd_addr;
    logic [31:0]  r_wb_addr;
    logic [255:0] r_wb_data;
    logic [31:0]  r_rdata;

    dcache_controller #(
        .LINES     (32),
        .LINE_BITS (256)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] line;
        for (int k = 0; k < 8; k++) begin
            line[k*32 +: 32] = base + step * k;
        end
        return line;
    endfunction

    // Drives one held CPU access and plays the memory side: ack on the n-th cycle of mem_req_o.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int n);
        int req_cnt;
        bit in_txn;
        bit done;
        req_cnt   = 0;
        in_txn    = 1'b0;
        done      = 1'b0;
        r_stalls  = 0;
        r_rd_cnt  = 0;
        r_wb_cnt  = 0;
        r_rd_addr = 32'hFFFF_FFFF;
        r_wb_addr = 32'hFFFF_FFFF;
        r_wb_data = '0;
        r_rdata   = 32'h0;
        @(negedge clk_i);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (!stall_o) begin
                r_rdata = rdata_o;
                done    = 1'b1;
            end else begin
                r_stalls++;
                if (mem_req_o) begin
                    if (!in_txn) begin
                        in_txn  = 1'b1;
                        req_cnt = 0;
                        if (mem_we_o) begin
                            r_wb_cnt++;
                            r_wb_addr = mem_addr_o;
                            r_wb_data = mem_wdata_o;
                        end else begin
                            r_rd_cnt++;
                            r_rd_addr = mem_addr_o;
                        end
                    end
                    req_cnt++;
                    if (req_cnt == n) begin
                        mem_ack_i = 1'b1;
                        if (mem_we_o) begin
                            mem_model[mem_addr_o] = mem_wdata_o;
                        end else begin
                            mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : '0;
                        end
                        in_txn = 1'b0;
                    end
                end
                @(negedge clk_i);
                mem_ack_i   = 1'b0;
                mem_rdata_i = '0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL access_timeout addr=%h still stalled after 200 cycles", addr);
        end
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b0;
        req_i       = 1'b1;
        we_i        = 1'b0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs stall=%b req=%b we=%b rdata=%h want 0 0 0 0",
                     stall_o, mem_req_o, mem_we_o, rdata_o);
        end
        req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_clean_refill();
        access(1'b0, 32'h0000_0000, 32'h0, 3);
        checks++;
        if (r_stalls !== 4) begin
            errors++;
            $display("FAIL refill_stalls got %0d want 4", r_stalls);
        end
        checks++;
        if (r_rd_cnt !== 1 || r_wb_cnt !== 0 || r_rd_addr !== 32'h0) begin
            errors++;
            $display("FAIL refill_mem rd=%0d wb=%0d addr=%h want 1 0 00000000", r_rd_cnt, r_wb_cnt, r_rd_addr);
        end
        checks++;
        if (r_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL refill_rdata got %h want 11111111", r_rdata);
        end
    endtask

    task automatic test_hits();
        access(1'b0, 32'h0000_001C, 32'h0, 1);
        checks++;
        if (r_stalls !== 0 || r_rdata !== 32'h8888_8888) begin
            errors++;
            $display("FAIL load_hit_word7 stalls=%0d rdata=%h want 0 88888888", r_stalls, r_rdata);
        end
        access(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1);
        checks++;
        if (r_stalls !== 0 || r_rd_cnt !== 0) begin
            errors++;
            $display("FAIL store_hit stalls=%0d reads=%0d want 0 0", r_stalls, r_rd_cnt);
        end
        access(1'b0, 32'h0000_0004, 32'h0, 1);
        checks++;
        if (r_stalls !== 0 || r_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_after_store stalls=%0d rdata=%h want 0 deadbeef", r_stalls, r_rdata);
        end
    endtask

    task automatic test_dirty_evict();
        access(1'b0, 32'h0000_0400, 32'h0, 3);
        checks++;
        if (r_stalls !== 7) begin
            errors++;
            $display("FAIL evict_stalls got %0d want 7", r_stalls);
        end
        checks++;
        if (r_wb_cnt !== 1 || r_wb_addr !== 32'h0) begin
            errors++;
            $display("FAIL evict_wb_addr count=%0d addr=%h want 1 00000000", r_wb_cnt, r_wb_addr);
        end
        checks++;
        if (r_wb_data[63:32] !== 32'hDEAD_BEEF || r_wb_data[31:0] !== 32'h1111_1111) begin
            errors++;
            $display("FAIL evict_wb_data w1=%h w0=%h want deadbeef 11111111", r_wb_data[63:32], r_wb_data[31:0]);
        end
        checks++;
        if (r_rd_addr !== 32'h0000_0400 || r_rdata !== 32'hA000_0000) begin
            errors++;
            $display("FAIL evict_refill addr=%h rdata=%h want 00000400 a0000000", r_rd_addr, r_rdata);
        end
        // The evicted line now lives in memory; reloading it is a clean miss with N = 1.
        access(1'b0, 32'h0000_0004, 32'h0, 1);
        checks++;
        if (r_stalls !== 2 || r_wb_cnt !== 0 || r_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reload_evicted stalls=%0d wb=%0d rdata=%h want 2 0 deadbeef", r_stalls, r_wb_cnt, r_rdata);
        end
    endtask

    task automatic test_store_miss();
        access(1'b1, 32'h0000_0828, 32'h1234_5678, 2);
        checks++;
        if (r_stalls !== 3 || r_wb_cnt !== 0 || r_rd_addr !== 32'h0000_0820) begin
            errors++;
            $display("FAIL store_miss stalls=%0d wb=%0d addr=%h want 3 0 00000820", r_stalls, r_wb_cnt, r_rd_addr);
        end
        access(1'b0, 32'h0000_0828, 32'h0, 1);
        checks++;
        if (r_stalls !== 0 || r_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL store_miss_word2 stalls=%0d rdata=%h want 0 12345678", r_stalls, r_rdata);
        end
        access(1'b0, 32'h0000_082C, 32'h0, 1);
        checks++;
        if (r_stalls !== 0 || r_rdata !== 32'hB000_0003) begin
            errors++;
            $display("FAIL store_miss_word3 stalls=%0d rdata=%h want 0 b0000003", r_stalls, r_rdata);
        end
        access(1'b0, 32'h0000_0020, 32'h0, 2);
        checks++;
        if (r_stalls !== 5 || r_wb_cnt !== 1 || r_wb_addr !== 32'h0000_0820) begin
            errors++;
            $display("FAIL conflict_wb stalls=%0d wb=%0d addr=%h want 5 1 00000820", r_stalls, r_wb_cnt, r_wb_addr);
        end
        checks++;
        if (r_wb_data[95:64] !== 32'h1234_5678 || r_wb_data[31:0] !== 32'hB000_0000) begin
            errors++;
            $display("FAIL conflict_wb_data w2=%h w0=%h want 12345678 b0000000", r_wb_data[95:64], r_wb_data[31:0]);
        end
        checks++;
        if (r_rd_addr !== 32'h0000_0020 || r_rdata !== 32'hC000_0000) begin
            errors++;
            $display("FAIL conflict_refill addr=%h rdata=%h want 00000020 c0000000", r_rd_addr, r_rdata);
        end
    endtask

    task automatic test_reset_mid_allocate();
        bit seen;
        seen = 1'b0;
        @(negedge clk_i);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h0000_0040;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            #1;
            if (mem_req_o) seen = 1'b1;
            else @(negedge clk_i);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_alloc_req mem_req_o=%b want 1 within 20 cycles", mem_req_o);
        end
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || mem_we_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset req=%b stall=%b we=%b rdata=%h want 0 0 0 0",
                     mem_req_o, stall_o, mem_we_o, rdata_o);
        end
        req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i   = 1'b1;
        mem_rdata_i = {8{32'h5555_5555}};
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack req=%b stall=%b want 0 0", mem_req_o, stall_o);
        end
        access(1'b0, 32'h0000_0040, 32'h0, 2);
        checks++;
        if (r_stalls !== 3 || r_rd_cnt !== 1 || r_rd_addr !== 32'h0000_0040 || r_rdata !== 32'hD000_0000) begin
            errors++;
            $display("FAIL reread_after_reset stalls=%0d rd=%0d addr=%h rdata=%h want 3 1 00000040 d0000000",
                     r_stalls, r_rd_cnt, r_rd_addr, r_rdata);
        end
        access(1'b0, 32'h0000_001C, 32'h0, 1);
        checks++;
        if (r_stalls !== 2 || r_rd_addr !== 32'h0 || r_rdata !== 32'h8888_8888) begin
            errors++;
            $display("FAIL line0_invalidated stalls=%0d addr=%h rdata=%h want 2 00000000 88888888",
                     r_stalls, r_rd_addr, r_rdata);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem_model[32'h0000_0000] = mk_line(32'h1111_1111, 32'h1111_1111);
        mem_model[32'h0000_0400] = mk_line(32'hA000_0000, 32'h1);
        mem_model[32'h0000_0820] = mk_line(32'hB000_0000, 32'h1);
        mem_model[32'h0000_0020] = mk_line(32'hC000_0000, 32'h1);
        mem_model[32'h0000_0040] = mk_line(32'hD000_0000, 32'h1);
        test_reset();
        test_clean_refill();
        test_hits();
        test_dirty_evict();
        test_store_miss();
        test_reset_mid_allocate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
